// File: rtl/vector_lsu_stream_if.sv
// OBI data-port bundle between the vector LSU (master) and memory (slave).
// Request: req/addr/we/be/wdata out of master; gnt/rvalid/rdata back in.
interface vector_lsu_stream_if;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o,
    output data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o,
    input  data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/vector_lsu_stream.sv
// Vector load/store unit: streams one OBI access per element (unit or
// strided), packs loads into a VLEN buffer and writes it back in one shot.
// Ports: clk, reset (sync, active-high); start_i/load_i/strided_i/vl_i/
// vsew_i/base_addr_i/stride_i command; busy_o/done_o/err_o status;
// obi (OBI master); vs_rdata_i store source; vs_wdata_o/vs_wbe_o/vr_we_o
// register write port.
// Option: define VLSU_STRIDED_EN to honour strided_i/stride_i.
module vector_lsu_stream #(
  parameter int VLEN            = 128,
  parameter int MAX_OUTSTANDING = 2,
  parameter int VL_W            = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                load_i,
  input  logic                strided_i,
  input  logic [VL_W-1:0]     vl_i,
  input  logic [1:0]          vsew_i,
  input  logic [31:0]         base_addr_i,
  input  logic [31:0]         stride_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  vector_lsu_stream_if.master obi,
  input  logic [VLEN-1:0]     vs_rdata_i,
  output logic [VLEN-1:0]     vs_wdata_o,
  output logic [VLEN/8-1:0]   vs_wbe_o,
  output logic                vr_we_o
);

  localparam int NB = VLEN / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, WB
  } state_t;

  state_t r_state, w_next;

  logic            r_load;
  logic [1:0]      r_sh;
  logic [31:0]     r_addr;
  logic [31:0]     r_raddr;
  logic [31:0]     r_stride;
  logic [CW-1:0]   r_eff;
  logic [CW-1:0]   r_issued;
  logic [CW-1:0]   r_rcvd;
  logic [OW-1:0]   r_outst;
  logic            r_err;
  logic [VLEN-1:0] r_vs;
  logic [VLEN-1:0] r_buf;

  logic [1:0]      w_in_sh;
  logic [CW-1:0]   w_max;
  logic [CW-1:0]   w_start_eff;
  logic [31:0]     w_start_stride;
  logic [3:0]      w_mask4;
  logic [31:0]     w_m32;
  logic            w_mis;
  logic            w_more;
  logic            w_req;
  logic            w_fire;
  logic            w_erring;
  logic            w_rv;
  logic [3:0]      w_be;
  logic [31:0]     w_boff;
  logic [31:0]     w_elem;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rel;
  logic [31:0]     w_roff;
  logic [VLEN-1:0] w_rmask;
  logic [VLEN-1:0] w_rdat;
  logic [31:0]     w_nbytes;
  logic [NB-1:0]   w_wbe;
  logic            w_done;
  logic            w_wb;
  logic            w_oe;

  // log2 of element size in bytes; vsew=3 is treated as 32 bit
  always_comb begin
    unique case (1'b1)
      vsew_i == 2'd0: w_in_sh = 2'd0;
      vsew_i == 2'd1: w_in_sh = 2'd1;
      default:        w_in_sh = 2'd2;
    endcase
  end

  assign w_max = CW'(NB) >> w_in_sh;
  assign w_start_eff =
    (32'(vl_i) < 32'(w_max)) ? CW'(vl_i) : w_max;

`ifdef VLSU_STRIDED_EN
  assign w_start_stride =
    strided_i ? stride_i : (32'd1 << w_in_sh);
`else
  logic w_unused;
  assign w_unused = ^{strided_i, stride_i};
  assign w_start_stride = 32'd1 << w_in_sh;
`endif

  always_comb begin
    unique case (1'b1)
      r_sh == 2'd0: w_mask4 = 4'h1;
      r_sh == 2'd1: w_mask4 = 4'h3;
      default:      w_mask4 = 4'hF;
    endcase
  end

  assign w_m32 = {{8{w_mask4[3]}}, {8{w_mask4[2]}},
                  {8{w_mask4[1]}}, {8{w_mask4[0]}}};

  assign w_mis = (r_sh == 2'd1 && r_addr[0]) ||
                 (r_sh >= 2'd2 && r_addr[1:0] != 2'd0);

  assign w_more   = (r_state == ISSUE) && (r_issued < r_eff);
  assign w_erring = w_more && w_mis;
  assign w_req    = w_more && !w_mis &&
                    (32'(r_outst) < MAX_OUTSTANDING);
  assign w_fire   = w_req && obi.data_gnt_i;
  // a response with nothing in flight is stale (e.g. from before reset)
  assign w_rv     = obi.data_rvalid_i && (r_outst != '0);

  assign w_be    = w_mask4 << r_addr[1:0];
  assign w_boff  = 32'(r_issued) << ({1'b0, r_sh} + 3'd3);
  assign w_elem  = 32'(r_vs >> w_boff);
  assign w_wdata = (w_elem & w_m32) << {r_addr[1:0], 3'b000};

  // responses come back in order, so a second address walker
  // recovers the byte lane of the k-th response
  assign w_rel   = (obi.data_rdata_i >> {r_raddr[1:0], 3'b000})
                   & w_m32;
  assign w_roff  = 32'(r_rcvd) << ({1'b0, r_sh} + 3'd3);
  assign w_rmask = VLEN'(w_m32) << w_roff;
  assign w_rdat  = VLEN'(w_rel) << w_roff;

  assign w_nbytes = 32'(r_eff) << r_sh;

  always_comb begin
    w_wbe = '0;
    for (int b = 0; b < NB; b++) begin
      w_wbe[b] = 32'(b) < w_nbytes;
    end
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_wb   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next = (w_start_eff == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (w_erring || r_issued == r_eff ||
            (w_fire && (r_issued + CW'(1)) == r_eff)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_outst == '0) begin
          if (r_load && !r_err && r_eff != '0) begin
            w_next = WB;
          end else begin
            w_next = IDLE;
            w_done = 1'b1;
          end
        end
      end
      WB: begin
        w_next = IDLE;
        w_done = 1'b1;
        w_wb   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // outputs fall to zero combinationally while reset is high
  assign w_oe = !reset;

  assign busy_o  = w_oe && (r_state != IDLE);
  assign done_o  = w_oe && w_done;
  assign err_o   = w_oe && w_done && r_err;
  assign vr_we_o = w_oe && w_wb;

  assign vs_wdata_o = (w_oe && w_wb) ? r_buf : '0;
  assign vs_wbe_o   = (w_oe && w_wb) ? w_wbe : '0;

  assign obi.data_req_o   = w_oe && w_req;
  assign obi.data_addr_o  = (w_oe && w_req) ? r_addr : '0;
  assign obi.data_we_o    = w_oe && w_req && !r_load;
  assign obi.data_be_o    = (w_oe && w_req) ? w_be : '0;
  assign obi.data_wdata_o =
    (w_oe && w_req && !r_load) ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_load   <= 1'b0;
      r_sh     <= '0;
      r_addr   <= '0;
      r_raddr  <= '0;
      r_stride <= '0;
      r_eff    <= '0;
      r_issued <= '0;
      r_rcvd   <= '0;
      r_outst  <= '0;
      r_err    <= 1'b0;
      r_vs     <= '0;
      r_buf    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_i) begin
        r_load   <= load_i;
        r_sh     <= w_in_sh;
        r_addr   <= base_addr_i;
        r_raddr  <= base_addr_i;
        r_stride <= w_start_stride;
        r_eff    <= w_start_eff;
        r_issued <= '0;
        r_rcvd   <= '0;
        r_err    <= 1'b0;
        r_vs     <= vs_rdata_i;
        r_buf    <= '0;
      end
      if (w_fire) begin
        r_issued <= r_issued + CW'(1);
        r_addr   <= r_addr + r_stride;
      end
      if (w_erring) begin
        r_err <= 1'b1;
      end
      if (w_rv) begin
        r_rcvd  <= r_rcvd + CW'(1);
        r_raddr <= r_raddr + r_stride;
        if (r_load) begin
          r_buf <= (r_buf & ~w_rmask) | w_rdat;
        end
      end
      unique case ({w_fire, w_rv})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lsu_stream.sv
// Self-checking bench for vector_lsu_stream: table of operations with a
// request scoreboard, plus a mid-operation reset sequence.
module tb_vector_lsu_stream;
  localparam int VLEN = 128;
  localparam int MAXO = 2;
  localparam int VL_W = 5;
  localparam int NB   = VLEN / 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_i = 1'b0;
  logic             load_i = 1'b0;
  logic             strided_i = 1'b0;
  logic [VL_W-1:0]  vl_i = '0;
  logic [1:0]       vsew_i = '0;
  logic [31:0]      base_addr_i = '0;
  logic [31:0]      stride_i = '0;
  logic             busy_o, done_o, err_o;
  logic [VLEN-1:0]  vs_rdata_i = '0;
  logic [VLEN-1:0]  vs_wdata_o;
  logic [NB-1:0]    vs_wbe_o;
  logic             vr_we_o;

  vector_lsu_stream_if bus();

  vector_lsu_stream #(
    .VLEN(VLEN), .MAX_OUTSTANDING(MAXO), .VL_W(VL_W)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .load_i(load_i), .strided_i(strided_i), .vl_i(vl_i),
    .vsew_i(vsew_i), .base_addr_i(base_addr_i),
    .stride_i(stride_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .obi(bus), .vs_rdata_i(vs_rdata_i),
    .vs_wdata_o(vs_wdata_o), .vs_wbe_o(vs_wbe_o),
    .vr_we_o(vr_we_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        ld;
    logic        strd;
    int          vl;
    logic [1:0]  sew;
    logic [31:0] base;
    logic [31:0] stride;
    int          gd;
    int          nreq;
    logic        err;
    logic [15:0] wbe;
  } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  req_t exp_q[$];
  int   gdly = 0;
  int   wcnt = 0;
  int   n_gnt = 0;
  logic rv_q = 1'b0;
  logic rv_inj = 1'b0;
  logic [31:0] rd_q = '0;
  logic [VLEN-1:0] vs_pat;
  vec_t vt[12];

  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h0100_0193) ^ 32'hC3A5_5A3C;
  endfunction

  assign bus.data_gnt_i    = bus.data_req_o && (wcnt >= gdly);
  assign bus.data_rvalid_i = rv_q | rv_inj;
  assign bus.data_rdata_i  = rd_q;

  // memory: grant after gdly waiting cycles, respond next cycle
  always @(posedge clk) begin
    if (bus.data_req_o && bus.data_gnt_i) begin
      rv_q <= 1'b1;
      rd_q <= memw(bus.data_addr_o);
      wcnt <= 0;
    end else begin
      rv_q <= 1'b0;
      if (bus.data_req_o) wcnt <= wcnt + 1;
    end
  end

  // every cycle with a request is checked against the scoreboard head
  always @(negedge clk) begin
    if (bus.data_req_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req: addr=%h be=%h",
                 bus.data_addr_o, bus.data_be_o);
      end else if ({bus.data_addr_o, bus.data_we_o,
                    bus.data_be_o, bus.data_wdata_o} !==
                   {exp_q[0].addr, exp_q[0].we,
                    exp_q[0].be, exp_q[0].wdata}) begin
        n_fail++;
        $display("FAIL req: got a=%h we=%b be=%h d=%h exp a=%h we=%b be=%h d=%h",
                 bus.data_addr_o, bus.data_we_o, bus.data_be_o,
                 bus.data_wdata_o, exp_q[0].addr, exp_q[0].we,
                 exp_q[0].be, exp_q[0].wdata);
      end
      if (bus.data_gnt_i) begin
        n_gnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic build_exp(input vec_t v, output logic [127:0] ebuf);
    int sewb, eff, maxe;
    logic [31:0] st, a, m32, e;
    logic [3:0] m, be;
    req_t r;
    sewb = 1 << v.sew;
    maxe = NB / sewb;
    eff = (v.vl < maxe) ? v.vl : maxe;
`ifdef VLSU_STRIDED_EN
    st = v.strd ? v.stride : 32'(sewb);
`else
    st = 32'(sewb);
`endif
    m = (sewb == 1) ? 4'h1 : (sewb == 2) ? 4'h3 : 4'hF;
    m32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    ebuf = '0;
    for (int i = 0; i < eff; i++) begin
      a = v.base + 32'(i) * st;
      if ((sewb == 2 && a[0]) || (sewb == 4 && a[1:0] != 2'd0))
        break;
      be = m << a[1:0];
      e = 32'(vs_pat >> (i * 8 * sewb)) & m32;
      r.addr = a;
      r.we = !v.ld;
      r.be = be;
      r.wdata = v.ld ? 32'd0 : (e << (8 * a[1:0]));
      exp_q.push_back(r);
      if (v.ld) begin
        e = (memw(a) >> (8 * a[1:0])) & m32;
        ebuf = ebuf | (128'(e) << (i * 8 * sewb));
      end
    end
  endtask

  task automatic run_op(input vec_t v);
    logic [127:0] ebuf, bm;
    logic wb;
    int lat;
    vs_pat = {$urandom, $urandom, $urandom, $urandom};
    exp_q.delete();
    build_exp(v, ebuf);
    gdly = v.gd;
    n_gnt = 0;
    start_i = 1'b1;
    load_i = v.ld;
    strided_i = v.strd;
    vl_i = VL_W'(v.vl);
    vsew_i = v.sew;
    base_addr_i = v.base;
    stride_i = v.stride;
    vs_rdata_i = vs_pat;
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
      if (done_o) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: no done_o base=%h", v.base);
    end else begin
      wb = v.ld && !v.err && v.nreq > 0;
      chk("err_o", 128'(err_o), 128'(v.err));
      chk("vr_we_o", 128'(vr_we_o), 128'(wb));
      chk("n_req", 128'(n_gnt), 128'(v.nreq));
      chk("sb_left", 128'(exp_q.size()), 128'd0);
      if (wb) begin
        chk("vs_wbe_o", 128'(vs_wbe_o), 128'(v.wbe));
        bm = '0;
        for (int b = 0; b < NB; b++)
          if (v.wbe[b]) bm[8*b +: 8] = 8'hFF;
        chk("vs_wdata_o", vs_wdata_o & bm, ebuf);
      end
      if (v.nreq == 0 && !v.err) chk("zero_vl_lat", 128'(lat), 128'd1);
      @(negedge clk);
      chk("done_once", 128'(done_o), 128'd0);
      chk("idle_busy", 128'(busy_o), 128'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] dummy;
    vec_t v23;
    int ok;
    vt[0]  = '{1'b1, 1'b0, 4,  2'd2, 32'h100, 32'd0, 0, 4, 1'b0, 16'hFFFF};
    vt[1]  = '{1'b1, 1'b1, 3,  2'd0, 32'h200, 32'd5, 0, 3, 1'b0, 16'h0007};
    vt[2]  = '{1'b0, 1'b0, 2,  2'd1, 32'h302, 32'd0, 3, 2, 1'b0, 16'h0000};
    vt[3]  = '{1'b1, 1'b0, 2,  2'd2, 32'h101, 32'd0, 0, 0, 1'b1, 16'h0000};
    vt[4]  = '{1'b1, 1'b0, 0,  2'd2, 32'h100, 32'd0, 0, 0, 1'b0, 16'h0000};
    vt[5]  = '{1'b1, 1'b0, 20, 2'd0, 32'h043, 32'd0, 0, 16, 1'b0, 16'hFFFF};
    vt[6]  = '{1'b1, 1'b0, 3,  2'd1, 32'h010, 32'd0, 1, 3, 1'b0, 16'h003F};
    vt[7]  = '{1'b0, 1'b0, 31, 2'd2, 32'h080, 32'd0, 0, 4, 1'b0, 16'h0000};
`ifdef VLSU_STRIDED_EN
    vt[8]  = '{1'b0, 1'b1, 3,  2'd1, 32'h3FE, 32'd3, 0, 1, 1'b1, 16'h0000};
`else
    vt[8]  = '{1'b0, 1'b1, 3,  2'd1, 32'h3FE, 32'd3, 0, 3, 1'b0, 16'h0000};
`endif
    vt[9]  = '{1'b1, 1'b0, 2,  2'd2, 32'hFFFF_FFFC, 32'd0, 0, 2, 1'b0, 16'h00FF};
    vt[10] = '{1'b1, 1'b0, 7,  2'd1, 32'h001, 32'd0, 0, 0, 1'b1, 16'h0000};
    vt[11] = '{1'b1, 1'b1, 8,  2'd1, 32'h022, 32'hFFFF_FFFE, 2, 8, 1'b0, 16'hFFFF};

    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_done", 128'(done_o), 128'd0);
    chk("rst_err", 128'(err_o), 128'd0);
    chk("rst_req", 128'(bus.data_req_o), 128'd0);
    chk("rst_vrwe", 128'(vr_we_o), 128'd0);
    chk("rst_wbe", 128'(vs_wbe_o), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(vt[i]);

    // reset in the middle of a clamped load
    v23 = '{1'b1, 1'b0, 8, 2'd2, 32'h100, 32'd0, 0, 4, 1'b0, 16'hFFFF};
    vs_pat = '0;
    exp_q.delete();
    build_exp(v23, dummy);
    gdly = 0;
    n_gnt = 0;
    start_i = 1'b1;
    load_i = 1'b1;
    strided_i = 1'b0;
    vl_i = VL_W'(8);
    vsew_i = 2'd2;
    base_addr_i = 32'h100;
    ok = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
      #1;
      if (n_gnt >= 2) begin
        ok = 1;
        break;
      end
    end
    chk("mid_two_grants", 128'(ok), 128'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_req_drop", 128'(bus.data_req_o), 128'd0);
    chk("mid_busy", 128'(busy_o), 128'd0);
    chk("mid_done", 128'(done_o), 128'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_busy", 128'(busy_o), 128'd0);
    chk("post_rst_req", 128'(bus.data_req_o), 128'd0);
    rv_inj = 1'b1;
    @(negedge clk);
    rv_inj = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("late_rv_busy", 128'(busy_o), 128'd0);
      chk("late_rv_done", 128'(done_o | vr_we_o), 128'd0);
      @(negedge clk);
    end
    run_op(vt[0]);
    run_op(vt[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_lsu_stream.md
VECTOR_LSU_STREAM -- requirements
Module: vector_lsu_stream

Interface
REQ-001 SHALL have parameter VLEN, default 128: vector register width in bits, multiple of 32.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: maximum number of granted OBI requests awaiting rvalid, range 1..8.
REQ-003 SHALL have parameter VL_W, default 5: width of vl_i.
REQ-004 SHALL use one clock, clk, and a synchronous, active-high reset, reset:
- clk  in  1  clock, rising-edge active
- reset  in  1  synchronous, active-high reset
- start_i  in  1  start request, single-cycle
- load_i  in  1  operation select: 1 = load, 0 = store
- strided_i  in  1  use stride_i as the element stride
- vl_i  in  VL_W  element count
- vsew_i  in  2  element width: 0 = 8 bit, 1 = 16 bit, 2 = 32 bit
- base_addr_i  in  32  address of element 0
- stride_i  in  32  byte stride, two's complement
- busy_o  out  1  operation in progress
- done_o  out  1  single-cycle completion pulse
- err_o  out  1  misalignment error, valid while done_o = 1
- data_req_o, data_addr_o[32], data_we_o, data_be_o[4], data_wdata_o[32]  out  OBI master request channel
- data_gnt_i, data_rvalid_i, data_rdata_i[32]  in  OBI master grant and response channel
- vs_rdata_i  in  VLEN  source register contents for stores
- vs_wdata_o  out  VLEN  packed load result
- vs_wbe_o  out  VLEN/8  byte write enables for the register write
- vr_we_o  out  1  register write strobe

Function
REQ-005 SHALL sample all control and operand inputs on the cycle start_i=1 in IDLE and hold them internally until the operation completes; start_i outside IDLE SHALL be ignored.
REQ-006 SHALL implement states IDLE, ISSUE, DRAIN, WB and SHALL assert busy_o=1 in every state except IDLE.
REQ-007 SHALL set eff_vl = min(vl_i, VLEN/SEW); if eff_vl = 0, SHALL issue no request and pulse done_o one cycle after start.
REQ-008 SHALL issue exactly one OBI transaction per element; element i address = base + i*stride (32-bit wrap), where stride = stride_i if strided_i=1, otherwise SEW/8.
REQ-009 SHALL drive data_be_o = SEW-byte mask << addr[1:0] and data_addr_o = full element address; for stores, data_wdata_o SHALL carry element i of vs_rdata_i shifted to byte lane addr[1:0].
REQ-010 In ISSUE, SHALL assert data_req_o while issued < eff_vl and outstanding < MAX_OUTSTANDING; address, data, byte enables and data_we_o SHALL stay stable until data_gnt_i.
REQ-011 outstanding SHALL increment on req&gnt and decrement on rvalid; simultaneous events SHALL leave it unchanged; rvalid with outstanding=0 SHALL be ignored.
REQ-012 Responses SHALL be in order; load response k SHALL extract the SEW-wide element at lane addr_k[1:0] and write it into buffer element k.
REQ-013 An element misaligned with respect to SEW (16-bit at addr[0]=1, or 32-bit at addr[1:0]!=0) SHALL not be requested; issue stops, err_o is latched, and the FSM goes to DRAIN.
REQ-014 SHALL go ISSUE->DRAIN when issued = eff_vl or on error, and SHALL leave DRAIN when outstanding = 0: to WB for an error-free load, otherwise to IDLE with done_o=1.
REQ-015 WB SHALL last one cycle: vr_we_o=1, vs_wdata_o=buffer, vs_wbe_o set for bytes of elements 0..eff_vl-1 only, done_o=1, next state IDLE.
REQ-016 Back-to-back operation: start_i in the cycle after done_o SHALL be accepted.

Reset
REQ-017 reset SHALL force state IDLE, clear all counters, the buffer and err_o, and drive every output to 0 in the same cycle; a reset in mid-operation SHALL drop data_req_o immediately, and rvalids after reset SHALL be ignored.

Configuration
REQ-018 Macro VLSU_STRIDED_EN: when defined, strided_i/stride_i behave per REQ-008; when undefined, strided_i and stride_i SHALL be ignored and stride SHALL always equal SEW/8.

Verification
REQ-019 Unit-stride load, vsew=2, vl=4, base=0x100, gnt same cycle, rvalid +1 -> addresses 0x100,0x104,0x108,0x10C; one vr_we_o, vs_wbe_o=0xFFFF.
REQ-020 Strided byte load, vsew=0, vl=3, base=0x200, stride=5 -> addresses 0x200,0x205,0x20A; be 0x1,0x2,0x4; vs_wbe_o=0x0007.
REQ-021 Store, vsew=1, vl=2, base=0x302, MAX_OUTSTANDING=1, gnt delayed 3 cycles -> request held stable; be 0xC then 0x3; no vr_we_o; done_o once.
REQ-022 Load, vsew=2, vl=2, base=0x101 -> no data_req_o; done_o=1 with err_o=1.
REQ-023 Load vl=8, vsew=2, VLEN=128 -> clamped to 4 requests; reset asserted after 2nd grant -> data_req_o=0 next cycle; FSM IDLE; late rvalid ignored.
